song_player: RTL
================

Name: song_player

Overview:
- Reader side of the song editor: takes the two 32-bit song words the editor writes and plays them back one 2-bit note per beat, as lane strobes for the game.
- Sits beside the editor, consumes the same `note1`/`note2` buses, and is active only in the play mode of the global 3-bit `mode`.
- Runs a count-in, steps a 5-bit position through 32 slots, supports pause, and flags completion.

Parameters:
- BEAT_CYCLES, 1_000_000, clock cycles per beat (must be >= 2).
- COUNTIN_BEATS, 4, beats of count-in before slot 0 (1..7).
- SONG_LEN, 32, number of slots played (1..32).

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- mode  input  3  global game mode; the player is active only when mode == PLAY_MODE (3'd3).
- start  input  1  single-cycle start/restart request.
- pause  input  1  level; freezes beat timing while high.
- note1  input  32  song slots 0-15; slot i is at bits [2i+1:2i].
- note2  input  32  song slots 16-31; slot i is at bits [2(i-16)+1:2(i-16)].
- position  output  5  current slot index.
- cur_note  output  2  note of the current slot.
- next_note  output  2  lookahead note for slot position+1; 2'b00 at the last slot.
- lane  output  4  one-hot of cur_note while in PLAY; 0 otherwise.
- beat  output  1  one-cycle pulse on every beat in COUNTIN and PLAY.
- countin  output  3  beats remaining in count-in; 0 outside COUNTIN.
- playing  output  1  high in PLAY.
- done  output  1  high in DONE.

Behaviour:
- Clock and reset: single clock `clk`. Reset is asynchronous and active-low on `nrst`.
- Reset values: state IDLE; every output 0; beat counter 0; snapshot registers 0.
- States:
  - IDLE -> COUNTIN when start && mode==PLAY_MODE. At that edge, note1/note2 are copied into snapshot registers (later editor writes do not affect playback), the beat counter is cleared, and countin is set to COUNTIN_BEATS.
  - COUNTIN:
    - Each tick decrements countin.
    - When countin==1 at a tick, go to PLAY with position=0 and cur_note=slot0 at that same edge.
  - PLAY:
    - Each tick: if position==SONG_LEN-1, go to DONE and clear lane.
    - Otherwise, increment position and update cur_note/next_note at the same edge.
  - DONE: hold position at SONG_LEN-1. start && mode==PLAY_MODE restarts (goes to COUNTIN with a fresh snapshot).
- Tick generation:
  - The beat counter runs 0..BEAT_CYCLES-1 in COUNTIN and PLAY.
  - tick = (counter==BEAT_CYCLES-1) && !pause. The counter wraps to 0 on tick.
  - The first tick therefore occurs BEAT_CYCLES cycles after entry.
  - beat is registered and is high during the cycle following the tick edge, coincident with the updated position/countin.
- Pause:
  - While pause is high, the counter holds and no ticks occur. Outputs hold.
  - pause in IDLE or DONE has no effect.
- Start while in COUNTIN or PLAY: restart, same as start from IDLE (new snapshot, counter cleared).
- Mode exit: mode != PLAY_MODE in any state other than IDLE returns to IDLE on the next edge and clears all outputs. This has priority over tick and start.
- Simultaneous events:
  - start and tick in the same cycle: start wins.
  - pause and start: start is accepted; the counter stays at 0 until pause falls.
- Next-slot note: next_note is the snapshot slot position+1, computed combinationally from the snapshot and registered with position.
- Width rule: position never exceeds SONG_LEN-1; no wrap-around to 0.

Decomposition:
- Package song_pkg:
  - PLAY_MODE = 3'd3.
  - typedef note_t (logic [1:0]).
  - enum player_state_t {IDLE, COUNTIN, PLAY, DONE}.
  - function slot_of(snapshot1, snapshot2, idx) returning note_t.
- Sub-module beat_timer:
  - Parameter BEAT_CYCLES.
  - Inputs: clk, nrst, clear, run (state in COUNTIN/PLAY), pause.
  - Output: tick.

Test Plan:
- BEAT_CYCLES=4, COUNTIN_BEATS=2; note1=32'h0000_00E4, mode=3, start pulse at cycle 0 -> countin 2,1 at beats (cycles 4,8); PLAY from edge 8; position 0..3 with cur_note 0,1,2,3; lane 0001,0010,0100,1000; each held 4 cycles; next_note leads by one slot.
- Same setup, run to the end -> after 32 play beats (128 cycles), done=1, playing=0, lane=0, position=31; beat pulses total 2+32.
- pause high for 10 cycles mid-slot 5 -> position stays 5 and no beat pulses during the pause; slot 5 lasts 14 cycles total.
- Change note1 to 32'hFFFF_FFFF during PLAY -> cur_note unaffected (snapshot); the next start picks up the new value (cur_note=3 at slot 0).
- mode changed to 3'd2 during PLAY slot 7 -> next edge IDLE, all outputs 0; start while mode!=3 -> stays IDLE.
- Assert nrst low mid-PLAY -> all outputs 0 immediately (asynchronous); after release, stays IDLE until start.

Source files
------------

// File: rtl/song_pkg.sv
// song_pkg: shared mode code, note type, player states and slot lookup for the song player
package song_pkg;
  localparam logic [2:0] PLAY_MODE = 3'd3;
  typedef logic [1:0] note_t;
  typedef enum logic [1:0] {IDLE, COUNTIN, PLAY, DONE} player_state_t;
  function automatic note_t slot_of(input logic [31:0] snapshot1, input logic [31:0] snapshot2,
                                    input logic [4:0] idx);
    logic [63:0] w;
    w = {snapshot2, snapshot1};
    return w[{idx, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/song_player_beat_timer.sv
// beat_timer: free-running beat divider that freezes on pause and restarts on clear
module beat_timer #(
  parameter int BEAT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic run,
  input  logic pause,
  output logic tick
);
  localparam int CW = $clog2(BEAT_CYCLES);
  logic [CW-1:0] cnt;
  assign tick = run && !pause && cnt == CW'(BEAT_CYCLES - 1);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) cnt <= '0;
    else cnt <= (clear || !run || tick) ? '0 : pause ? cnt : cnt + 1'b1;
endmodule

// File: rtl/song_player.sv
// song_player: plays a snapshotted 32-slot song as per-beat lane strobes after a count-in
module song_player
  import song_pkg::*;
#(
  parameter int BEAT_CYCLES   = 1_000_000,
  parameter int COUNTIN_BEATS = 4,
  parameter int SONG_LEN      = 32
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [2:0]  mode,
  input  logic        start,
  input  logic        pause,
  input  logic [31:0] note1,
  input  logic [31:0] note2,
  output logic [4:0]  position,
  output logic [1:0]  cur_note,
  output logic [1:0]  next_note,
  output logic [3:0]  lane,
  output logic        beat,
  output logic [2:0]  countin,
  output logic        playing,
  output logic        done
);
  localparam logic [4:0] LAST = 5'(SONG_LEN - 1);
  player_state_t state, state_n;
  logic [31:0] snap1, snap1_n, snap2, snap2_n;
  logic [4:0] pos_n;
  note_t cur_n, next_n;
  logic [2:0] countin_n;
  logic beat_n, clear, tick, go, run;
  assign run = state == COUNTIN || state == PLAY;
  assign go = start && mode == PLAY_MODE;
  assign playing = state == PLAY;
  assign done = state == DONE;
  assign lane = playing ? 4'(1) << cur_note : '0;
  beat_timer #(.BEAT_CYCLES(BEAT_CYCLES)) u_timer (
    .clk(clk), .nrst(nrst), .clear(clear), .run(run), .pause(pause), .tick(tick)
  );
  always_comb begin
    state_n   = state;
    snap1_n   = snap1;
    snap2_n   = snap2;
    pos_n     = position;
    cur_n     = cur_note;
    next_n    = next_note;
    countin_n = countin;
    beat_n    = 1'b0;
    clear     = 1'b0;
    if (mode != PLAY_MODE) begin
      state_n   = IDLE;
      pos_n     = '0;
      cur_n     = '0;
      next_n    = '0;
      countin_n = '0;
      clear     = 1'b1;
    end else if (go) begin
      state_n   = COUNTIN;
      snap1_n   = note1;
      snap2_n   = note2;
      pos_n     = '0;
      cur_n     = '0;
      next_n    = '0;
      countin_n = 3'(COUNTIN_BEATS);
      clear     = 1'b1;
    end else if (tick) begin
      beat_n = 1'b1;
      if (state == COUNTIN) begin
        countin_n = countin - 3'd1;
        if (countin == 3'd1) begin
          state_n = PLAY;
          pos_n   = '0;
          cur_n   = slot_of(snap1, snap2, 5'd0);
          next_n  = (LAST == 5'd0) ? '0 : slot_of(snap1, snap2, 5'd1);
        end
      end else if (position == LAST) begin
        state_n = DONE;
      end else begin
        pos_n  = position + 5'd1;
        cur_n  = slot_of(snap1, snap2, position + 5'd1);
        // lookahead goes silent once the new slot is the final one
        next_n = (position + 5'd1 == LAST) ? '0 : slot_of(snap1, snap2, position + 5'd2);
      end
    end
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state     <= IDLE;
      snap1     <= '0;
      snap2     <= '0;
      position  <= '0;
      cur_note  <= '0;
      next_note <= '0;
      countin   <= '0;
      beat      <= 1'b0;
    end else begin
      state     <= state_n;
      snap1     <= snap1_n;
      snap2     <= snap2_n;
      position  <= pos_n;
      cur_note  <= cur_n;
      next_note <= next_n;
      countin   <= countin_n;
      beat      <= beat_n;
    end
endmodule
